// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for mem_arbiter: FSM state encoding, load/store size
// codes, grant ids and the size-code to byte-count helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MS_IDLE  = 2'd0,
    MS_READ  = 2'd1,
    MS_WRITE = 2'd2,
    MS_DONE  = 2'd3
  } mem_state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic GR_IF = 1'b0;
  localparam logic GR_LS = 1'b1;

  // Size code 11 is illegal and is handled as a word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial controller sharing one 8-bit RAM port between
// instruction fetch (always 4 bytes) and the load/store unit (1/2/4 bytes).
// Read words are assembled little-endian; store data is split into bytes.
//
// Ports
//   clk_in, rst_in (async, active low), rdy_in (low pauses issue)
//   if_req_in/if_addr_in/if_abort_in -> if_done_out/if_data_out
//   ls_req_in/ls_we_in/ls_size_in/ls_addr_in/ls_wdata_in -> ls_done_out/ls_rdata_out
//   ram_en_out/ram_r_nw_out/ram_a_out/ram_d_out, ram_d_in (valid one cycle after issue)
//   dbg_state_out: current FSM state
//
// Handshake: each requester holds its req level until it sees its done pulse
// (exactly one cycle) and drops req at the edge where it samples done. The
// data output is valid during done and holds until that port's next done.
// The DONE state ignores requests, so a held req is never granted twice.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  if_req_in,
  input  logic [31:0]           if_addr_in,
  input  logic                  if_abort_in,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,
  input  logic                  ls_req_in,
  input  logic                  ls_we_in,
  input  logic [1:0]            ls_size_in,
  input  logic [31:0]           ls_addr_in,
  input  logic [31:0]           ls_wdata_in,
  output logic                  ls_done_out,
  output logic [31:0]           ls_rdata_out,
  output logic                  ram_en_out,
  output logic                  ram_r_nw_out,
  output logic [ADDR_WIDTH-1:0] ram_a_out,
  output logic [7:0]            ram_d_out,
  input  logic [7:0]            ram_d_in,
  output mem_state_t            dbg_state_out
);

  mem_state_t            r_state, w_state_next;
  logic                  r_grant;      // last/current grant
  logic                  r_we;
  logic [2:0]            r_n;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [31:0]           r_wdata;
  logic [2:0]            r_issue_cnt;
  logic [2:0]            r_cap_cnt;
  logic                  r_pending;
  logic [31:0]           r_buf;
  logic [31:0]           r_if_hold;
  logic [31:0]           r_ls_hold;

  logic                  w_fire;
  logic                  w_sel;
  logic                  w_abort_rd;
  logic                  w_cap_done;
  logic [31:0]           w_buf_ins;
  logic [7:0]            w_wr_byte;
  logic                  w_unused_bits;

  assign w_unused_bits = ^{if_addr_in[31:ADDR_WIDTH], ls_addr_in[31:ADDR_WIDTH]};

  assign dbg_state_out = r_state;
  assign w_abort_rd    = (r_state == MS_READ) && (r_grant == GR_IF) && if_abort_in;

  assign ram_en_out   = ((r_state == MS_READ) || (r_state == MS_WRITE)) &&
                        (r_issue_cnt < r_n) && rdy_in;
  assign ram_r_nw_out = (r_state != MS_WRITE);
  assign ram_a_out    = r_base + ADDR_WIDTH'(r_issue_cnt);
  assign ram_d_out    = (r_state == MS_WRITE) ? w_wr_byte : 8'h00;

  // A capture in flight finishes the read when it fills the last lane; if
  // rdy_in was low at that edge, the FSM leaves on a later ready edge instead.
  assign w_cap_done = r_pending ? (r_cap_cnt == r_n - 3'd1) : (r_cap_cnt == r_n);

  assign if_done_out  = (r_state == MS_DONE) && (r_grant == GR_IF) && !if_abort_in;
  assign ls_done_out  = (r_state == MS_DONE) && (r_grant == GR_LS);
  assign if_data_out  = if_done_out ? r_buf : r_if_hold;
  assign ls_rdata_out = (ls_done_out && !r_we) ? r_buf : r_ls_hold;

  always_comb begin
    w_buf_ins = r_buf;
    case (r_cap_cnt)
      3'd0:    w_buf_ins[7:0]   = ram_d_in;
      3'd1:    w_buf_ins[15:8]  = ram_d_in;
      3'd2:    w_buf_ins[23:16] = ram_d_in;
      3'd3:    w_buf_ins[31:24] = ram_d_in;
      default: w_buf_ins = r_buf;
    endcase
  end

  always_comb begin
    w_wr_byte = 8'h00;
    case (r_issue_cnt)
      3'd0:    w_wr_byte = r_wdata[7:0];
      3'd1:    w_wr_byte = r_wdata[15:8];
      3'd2:    w_wr_byte = r_wdata[23:16];
      3'd3:    w_wr_byte = r_wdata[31:24];
      default: w_wr_byte = 8'h00;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_fire       = 1'b0;
    w_sel        = r_grant;
    case (r_state)
      MS_IDLE: begin
        if (rdy_in && (if_req_in || ls_req_in)) begin
          w_fire = 1'b1;
          if (ls_req_in && !if_req_in)      w_sel = GR_LS;
          else if (if_req_in && !ls_req_in) w_sel = GR_IF;
          else                              w_sel = ~r_grant;  // alternate on ties
          w_state_next = (w_sel == GR_LS && ls_we_in) ? MS_WRITE : MS_READ;
        end
      end
      MS_READ: begin
        if (w_abort_rd)                 w_state_next = MS_IDLE;
        else if (rdy_in && w_cap_done)  w_state_next = MS_DONE;
      end
      MS_WRITE: begin
        if (ram_en_out && (r_issue_cnt == r_n - 3'd1)) w_state_next = MS_DONE;
      end
      MS_DONE:  w_state_next = MS_IDLE;
      default:  w_state_next = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= MS_IDLE;
      r_grant     <= GR_IF;
      r_we        <= 1'b0;
      r_n         <= 3'd0;
      r_base      <= '0;
      r_wdata     <= 32'h0;
      r_issue_cnt <= 3'd0;
      r_cap_cnt   <= 3'd0;
      r_pending   <= 1'b0;
      r_buf       <= 32'h0;
      r_if_hold   <= 32'h0;
      r_ls_hold   <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (w_fire) begin
        r_grant     <= w_sel;
        r_we        <= (w_sel == GR_LS) && ls_we_in;
        r_n         <= (w_sel == GR_LS) ? size_to_bytes(ls_size_in) : 3'd4;
        r_base      <= (w_sel == GR_LS) ? ls_addr_in[ADDR_WIDTH-1:0]
                                        : if_addr_in[ADDR_WIDTH-1:0];
        r_wdata     <= ((w_sel == GR_LS) && ls_we_in) ? ls_wdata_in : 32'h0;
        r_issue_cnt <= 3'd0;
        r_cap_cnt   <= 3'd0;
        r_pending   <= 1'b0;
        r_buf       <= 32'h0;  // unused lanes stay zero: loads are zero-extended
      end else begin
        if (ram_en_out) r_issue_cnt <= r_issue_cnt + 3'd1;
        // Capture is independent of rdy_in; an abort drops the byte in flight.
        r_pending <= ram_en_out && (r_state == MS_READ) && !w_abort_rd;
        if (r_pending) begin
          r_buf     <= w_buf_ins;
          r_cap_cnt <= r_cap_cnt + 3'd1;
        end
      end
      if (if_done_out)            r_if_hold <= r_buf;
      if (ls_done_out && !r_we)   r_ls_hold <= r_buf;
    end
  end

endmodule
